ll_rx_framer: RTL and testbench

LL_RX_FRAMER -- requirements
Module: ll_rx_framer

---
 rtl/ll_pkg.sv | 43 ++++
 rtl/ll_rx_framer.sv | 151 +++++++++++++++
 tb/tb_ll_rx_framer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_pkg.sv
// Shared definitions for the LocalLink RX framer: FSM state encoding, REM
// byte-valid masks and the default frame layout.
package ll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_FOOT    = 2'd3
  } ll_state_t;

  // Active-low byte-valid masks on the last payload word.
  localparam logic [3:0] REM_4B = 4'b0000;
  localparam logic [3:0] REM_3B = 4'b0001;
  localparam logic [3:0] REM_2B = 4'b0011;
  localparam logic [3:0] REM_1B = 4'b0111;
  localparam logic [3:0] REM_0B = 4'b1111;

  localparam int DEF_HDR_WORDS = 8;
  localparam int DEF_FTR_WORDS = 8;
  localparam int DEF_FLAG_IDX  = 4;
  localparam int DEF_LEN_IDX   = 5;

  // Valid bytes on a last word = number of zero bits in the mask.
  function automatic logic [31:0] rem_bytes(input logic [3:0] rem);
    logic [31:0] n;
    case (rem)
      REM_4B:  n = 32'd4;
      REM_3B:  n = 32'd3;
      REM_2B:  n = 32'd2;
      REM_1B:  n = 32'd1;
      REM_0B:  n = 32'd0;
      default: begin
        n = 32'd0;
        for (int i = 0; i < 4; i++) begin
          if (!rem[i]) n = n + 32'd1;
        end
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ll_rx_framer.sv
// Wraps a payload stream from the compression core into a LocalLink RX frame:
// fixed header, pass-through payload, footer carrying the flag and byte count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no frame; waits for s_valid, then latches s_flag
// HEAD    | emits HDR_WORDS header words (SOF on word 0, flag word)
// PAYLOAD | passes s_data through, counts bytes, SOP/EOP framing
// FOOT    | emits FTR_WORDS footer words (flag, byte count, EOF on last)
module ll_rx_framer
  import ll_pkg::*;
#(
  parameter int HDR_WORDS = DEF_HDR_WORDS,
  parameter int FTR_WORDS = DEF_FTR_WORDS,
  parameter int FLAG_IDX  = DEF_FLAG_IDX,
  parameter int LEN_IDX   = DEF_LEN_IDX
) (
  input  logic        CPMDMALLCLK,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic [3:0]  s_rem,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_flag,
  output logic [31:0] LLDMARXD,
  output logic [3:0]  LLDMARXREM,
  output logic        LLDMARXSOFN,
  output logic        LLDMARXEOFN,
  output logic        LLDMARXSOPN,
  output logic        LLDMARXEOPN,
  output logic        LLDMARXSRCRDYN,
  input  logic        DMALLRXDSTRDYN,
  output logic        frame_done,
  output logic [31:0] byte_count
);

  localparam logic [2:0] HDR_LAST = 3'(HDR_WORDS - 1);
  localparam logic [2:0] FTR_LAST = 3'(FTR_WORDS - 1);
  localparam logic [2:0] FLAG_I   = 3'(FLAG_IDX);
  localparam logic [2:0] LEN_I    = 3'(LEN_IDX);

  ll_state_t   state_q, state_d;
  logic [2:0]  idx_q;
  logic [31:0] flag_q;
  logic [31:0] byte_count_q;
  logic        sop_pend_q;
  logic        frame_done_q;
  logic        xfer;

  assign xfer       = ~LLDMARXSRCRDYN & ~DMALLRXDSTRDYN;
  assign frame_done = frame_done_q;
  assign byte_count = byte_count_q;

  always_ff @(posedge CPMDMALLCLK or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (s_valid) state_d = ST_HEAD;
      ST_HEAD:    if (xfer && idx_q == HDR_LAST) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (xfer && s_last) state_d = ST_FOOT;
      ST_FOOT:    if (xfer && idx_q == FTR_LAST) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Index, latched flag, byte counter and SOP tracking advance only on transfers.
  always_ff @(posedge CPMDMALLCLK or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= 3'd0;
      flag_q       <= 32'd0;
      byte_count_q <= 32'd0;
      sop_pend_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state_q == ST_FOOT) && xfer && (idx_q == FTR_LAST);
      unique case (state_q)
        ST_IDLE: begin
          if (s_valid) begin
            flag_q       <= s_flag;
            byte_count_q <= 32'd0;
            idx_q        <= 3'd0;
          end
        end
        ST_HEAD: begin
          if (xfer) begin
            if (idx_q == HDR_LAST) begin
              idx_q      <= 3'd0;
              sop_pend_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            byte_count_q <= byte_count_q + (s_last ? rem_bytes(s_rem) : 32'd4);
            sop_pend_q   <= 1'b0;
            if (s_last) idx_q <= 3'd0;
          end
        end
        ST_FOOT: begin
          if (xfer) begin
            if (idx_q == FTR_LAST) idx_q <= 3'd0;
            else                   idx_q <= idx_q + 3'd1;
          end
        end
        default: idx_q <= 3'd0;
      endcase
    end
  end

  always_comb begin
    s_ready        = 1'b0;
    LLDMARXD       = 32'd0;
    LLDMARXREM     = REM_4B;
    LLDMARXSOFN    = 1'b1;
    LLDMARXEOFN    = 1'b1;
    LLDMARXSOPN    = 1'b1;
    LLDMARXEOPN    = 1'b1;
    LLDMARXSRCRDYN = 1'b1;
    unique case (state_q)
      ST_IDLE: ;
      ST_HEAD: begin
        LLDMARXSRCRDYN = 1'b0;
        LLDMARXSOFN    = (idx_q != 3'd0);
        if (idx_q == FLAG_I) LLDMARXD = flag_q;
      end
      ST_PAYLOAD: begin
        LLDMARXD       = s_data;
        LLDMARXSRCRDYN = ~s_valid;
        s_ready        = ~DMALLRXDSTRDYN;
        LLDMARXSOPN    = ~sop_pend_q;
        LLDMARXEOPN    = ~s_last;
        if (s_last) LLDMARXREM = s_rem;
      end
      ST_FOOT: begin
        LLDMARXSRCRDYN = 1'b0;
        LLDMARXEOFN    = (idx_q != FTR_LAST);
        if (idx_q == FLAG_I)     LLDMARXD = flag_q;
        else if (idx_q == LEN_I) LLDMARXD = byte_count_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ll_rx_framer.sv
// Randomized bench for ll_rx_framer: every observed LocalLink transfer is
// compared against a frame built directly from the header/payload/footer rules.
module tb_ll_rx_framer;

  localparam int HDR = 8;
  localparam int FTR = 8;

  logic        CPMDMALLCLK = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic [3:0]  s_rem;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_flag;
  logic [31:0] LLDMARXD;
  logic [3:0]  LLDMARXREM;
  logic        LLDMARXSOFN, LLDMARXEOFN, LLDMARXSOPN, LLDMARXEOPN;
  logic        LLDMARXSRCRDYN;
  logic        DMALLRXDSTRDYN;
  logic        frame_done;
  logic [31:0] byte_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  rem;
    logic        sofn;
    logic        eofn;
    logic        sopn;
    logic        eopn;
  } xfer_t;

  xfer_t got_q[$];
  xfer_t exp_q[$];

  always #5 CPMDMALLCLK = ~CPMDMALLCLK;

  ll_rx_framer dut (
    .CPMDMALLCLK    (CPMDMALLCLK),
    .rst_n          (rst_n),
    .s_data         (s_data),
    .s_rem          (s_rem),
    .s_last         (s_last),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_flag         (s_flag),
    .LLDMARXD       (LLDMARXD),
    .LLDMARXREM     (LLDMARXREM),
    .LLDMARXSOFN    (LLDMARXSOFN),
    .LLDMARXEOFN    (LLDMARXEOFN),
    .LLDMARXSOPN    (LLDMARXSOPN),
    .LLDMARXEOPN    (LLDMARXEOPN),
    .LLDMARXSRCRDYN (LLDMARXSRCRDYN),
    .DMALLRXDSTRDYN (DMALLRXDSTRDYN),
    .frame_done     (frame_done),
    .byte_count     (byte_count)
  );

  function automatic logic [3:0] pick_rem();
    case ($urandom_range(0, 4))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0011;
      3: return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    logic [9:0] got, want;
    got  = {LLDMARXSRCRDYN, LLDMARXSOFN, LLDMARXEOFN, LLDMARXSOPN, LLDMARXEOPN,
            s_ready, frame_done, (LLDMARXD != 0), (LLDMARXREM != 0), (byte_count != 0)};
    want = 10'b11111_00000;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s idle_outputs got=%b want=%b", tag, got, want);
    end
  endtask

  // Runs one frame; when abort_at >= 0 it returns right after that many
  // payload words were accepted, leaving the frame unfinished.
  task automatic run_frame(input string tag, input logic [31:0] flag, input int nwords,
                           input logic [3:0] last_rem, input int dst_mode, input int gap_len,
                           input int abort_at);
    logic [31:0] words[$];
    int pi, gap, cyc, eof_cyc, fd_cyc;
    bit gap_err, done, hs;
    logic [31:0] total;
    xfer_t e;

    words.delete();
    for (int i = 0; i < nwords; i++) words.push_back($urandom);
    total = 32'(4 * (nwords - 1) + (4 - $countones(last_rem)));

    exp_q.delete();
    for (int h = 0; h < HDR; h++) begin
      e = '{d: (h == 4) ? flag : 32'd0, rem: 4'b0000, sofn: (h != 0), eofn: 1'b1,
            sopn: 1'b1, eopn: 1'b1};
      exp_q.push_back(e);
    end
    for (int i = 0; i < nwords; i++) begin
      e = '{d: words[i], rem: (i == nwords - 1) ? last_rem : 4'b0000, sofn: 1'b1,
            eofn: 1'b1, sopn: (i != 0), eopn: (i != nwords - 1)};
      exp_q.push_back(e);
    end
    for (int f = 0; f < FTR; f++) begin
      e = '{d: (f == 4) ? flag : (f == 5) ? total : 32'd0, rem: 4'b0000, sofn: 1'b1,
            eofn: (f != FTR - 1), sopn: 1'b1, eopn: 1'b1};
      exp_q.push_back(e);
    end

    got_q.delete();
    s_flag  = flag;
    pi      = 0;
    gap     = 0;
    cyc     = 0;
    eof_cyc = -1;
    fd_cyc  = -1;
    gap_err = 0;
    done    = 0;
    s_valid = 1'b1;
    s_data  = words[0];
    s_last  = (nwords == 1);
    s_rem   = (nwords == 1) ? last_rem : 4'($urandom);

    while (!done && cyc < 3000) begin
      case (dst_mode)
        0:       DMALLRXDSTRDYN = 1'b0;
        1:       DMALLRXDSTRDYN = cyc[0];
        default: DMALLRXDSTRDYN = 1'($urandom_range(0, 1));
      endcase
      @(negedge CPMDMALLCLK);
      if (got_q.size() >= HDR && pi < nwords && !s_valid && LLDMARXSRCRDYN !== 1'b1)
        gap_err = 1;
      if (LLDMARXSRCRDYN === 1'b0 && DMALLRXDSTRDYN === 1'b0) begin
        got_q.push_back('{d: LLDMARXD, rem: LLDMARXREM, sofn: LLDMARXSOFN,
                          eofn: LLDMARXEOFN, sopn: LLDMARXSOPN, eopn: LLDMARXEOPN});
        if (LLDMARXEOFN === 1'b0) eof_cyc = cyc;
      end
      if (frame_done === 1'b1) begin
        fd_cyc = cyc;
        done   = 1;
      end
      hs = s_valid && (s_ready === 1'b1);
      @(posedge CPMDMALLCLK);
      #1;
      cyc++;
      s_flag = $urandom;
      if (hs) begin
        pi++;
        if (pi == abort_at) return;
        gap = gap_len;
      end
      if (pi >= nwords) begin
        s_valid = 1'b0;
      end else if (gap > 0) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        s_last  = 1'($urandom);
        gap--;
      end else begin
        s_valid = 1'b1;
        s_data  = words[pi];
        s_last  = (pi == nwords - 1);
        s_rem   = (pi == nwords - 1) ? last_rem : 4'($urandom);
      end
    end
    s_valid = 1'b0;

    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout got_frame_done=0 want=1 after %0d cycles", tag, cyc);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s transfer_count got=%0d want=%0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s word%0d got=%h want=%h", tag, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (byte_count !== total) begin
      failures++;
      $display("FAIL %s byte_count got=%0d want=%0d", tag, byte_count, total);
    end
    checks++;
    if (fd_cyc != eof_cyc + 1 || eof_cyc < 0) begin
      failures++;
      $display("FAIL %s frame_done_timing got=%0d want=%0d", tag, fd_cyc, eof_cyc + 1);
    end
    checks++;
    if (gap_err) begin
      failures++;
      $display("FAIL %s gap_srcrdyn got=0 want=1", tag);
    end
    // frame_done is a single-cycle pulse
    @(negedge CPMDMALLCLK);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL %s frame_done_pulse got=%b want=0", tag, frame_done);
    end
    @(posedge CPMDMALLCLK);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = 32'd0;
    s_rem = 4'd0;
    s_last = 1'b0;
    s_flag = 32'd0;
    DMALLRXDSTRDYN = 1'b0;
    repeat (3) @(posedge CPMDMALLCLK);
    #1;
    check_idle_outputs("reset");
    @(negedge CPMDMALLCLK);
    rst_n = 1'b1;
    @(posedge CPMDMALLCLK);
    #1;
    check_idle_outputs("post_reset");
  endtask

  task automatic test_basic();
    run_frame("basic", 32'h2000_0000, 3, 4'b0000, 0, 0, -1);
  endtask

  task automatic test_single_word();
    run_frame("single", $urandom, 1, 4'b0111, 0, 0, -1);
  endtask

  task automatic test_dst_toggle();
    run_frame("dst_toggle", $urandom, 5, 4'b0000, 1, 0, -1);
  endtask

  task automatic test_gaps();
    run_frame("gaps", $urandom, 4, pick_rem(), 0, 3, -1);
    run_frame("gaps_toggle", $urandom, 3, pick_rem(), 1, 3, -1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++)
      run_frame($sformatf("rand%0d", k), $urandom, $urandom_range(1, 12), pick_rem(),
                2, $urandom_range(0, 2), -1);
  endtask

  task automatic test_mid_reset();
    run_frame("abort", $urandom, 5, 4'b0000, 0, 0, 2);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    s_valid = 1'b0;
    @(negedge CPMDMALLCLK);
    rst_n = 1'b1;
    @(posedge CPMDMALLCLK);
    #1;
    run_frame("after_reset", $urandom, 2, 4'b0011, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_word();
    test_dst_toggle();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
